// File: rtl/fn_from_rec_fn_wb.sv
// Recoded-double (recFN) to IEEE-754 binary64 writeback stage: converts on the
// way in, buffers {data, tag} in a 2-entry in-order FIFO, and accumulates fflags.
module fn_from_rec_fn_wb #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [64:0]      io_in_bits_rec,
  input  logic [4:0]       io_in_bits_flags,
  input  logic [TAG_W-1:0] io_in_bits_tag,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [63:0]      io_out_bits_data,
  output logic [TAG_W-1:0] io_out_bits_tag,
  output logic [4:0]       io_fflags,
  input  logic             io_fflagsClear,
  output logic [1:0]       io_count
);

  localparam logic [1:0] CNT_MAX = 2'(DEPTH);

  // Subnormals come out of recFN with exponents below 1026; the shift amount is
  // taken modulo 64, so exponents far below the subnormal range alias.
  function automatic logic [63:0] rec_to_ieee(input logic [64:0] rec);
    logic        sign;
    logic [11:0] exp_in;
    logic [51:0] fract;
    logic [5:0]  shift_dist;
    logic [52:0] sub_mant;
    logic [10:0] exp_out;
    logic [51:0] fract_out;
    sign       = rec[64];
    exp_in     = rec[63:52];
    fract      = rec[51:0];
    shift_dist = 6'd1 - exp_in[5:0];
    sub_mant   = ({1'b1, fract} >> 1) >> shift_dist;
    exp_out    = 11'd0;
    fract_out  = 52'd0;
    case (exp_in[11:9])
      3'b000: begin
        exp_out   = 11'd0;
        fract_out = 52'd0;
      end
      3'b110: begin
        exp_out   = 11'h7FF;
        fract_out = 52'd0;
      end
      3'b111: begin
        exp_out   = 11'h7FF;
        fract_out = fract;
      end
      default: begin
        if (exp_in < 12'd1026) begin
          exp_out   = 11'd0;
          fract_out = sub_mant[51:0];
        end else begin
          exp_out   = exp_in[10:0] - 11'd1025;
          fract_out = fract;
        end
      end
    endcase
    return {sign, exp_out, fract_out};
  endfunction

  logic [63:0]      data_q [0:1];
  logic [63:0]      data_d [0:1];
  logic [TAG_W-1:0] tag_q  [0:1];
  logic [TAG_W-1:0] tag_d  [0:1];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             in_fire_s, out_fire_s;
  logic [63:0]      conv_data_s;

  // Handshake derived only from registered occupancy.
  always_comb begin
    io_in_ready  = (count_q < CNT_MAX);
    io_out_valid = (count_q != 2'd0);
    in_fire_s    = io_in_valid & io_in_ready;
    out_fire_s   = io_out_valid & io_out_ready;
    conv_data_s  = rec_to_ieee(io_in_bits_rec);
  end

  // Next-state for FIFO storage, pointers, occupancy and sticky flags.
  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;
    if (in_fire_s) begin
      data_d[wr_ptr_q] = conv_data_s;
      tag_d[wr_ptr_q]  = io_in_bits_tag;
      wr_ptr_d         = ~wr_ptr_q;
      fflags_d         = (io_fflagsClear ? 5'd0 : fflags_q) | io_in_bits_flags;
    end else if (io_fflagsClear) begin
      fflags_d = 5'd0;
    end else begin
      fflags_d = fflags_q;
    end
    if (out_fire_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({in_fire_s, out_fire_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards any buffered entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q[0] <= 64'd0;
      data_q[1] <= 64'd0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      fflags_q  <= 5'd0;
    end else begin
      data_q    <= data_d;
      tag_q     <= tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fflags_q  <= fflags_d;
    end
  end

  // Head entry is presented only while occupied, zeros otherwise.
  always_comb begin
    if (count_q != 2'd0) begin
      io_out_bits_data = data_q[rd_ptr_q];
      io_out_bits_tag  = tag_q[rd_ptr_q];
    end else begin
      io_out_bits_data = 64'd0;
      io_out_bits_tag  = '0;
    end
    io_fflags = fflags_q;
    io_count  = count_q;
  end

endmodule

// File: tb/tb_fn_from_rec_fn_wb.sv
// Self-checking bench for fn_from_rec_fn_wb: directed vectors with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_fn_from_rec_fn_wb;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [64:0]      io_in_bits_rec = 65'd0;
  logic [4:0]       io_in_bits_flags = 5'd0;
  logic [TAG_W-1:0] io_in_bits_tag = '0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic [63:0]      io_out_bits_data;
  logic [TAG_W-1:0] io_out_bits_tag;
  logic [4:0]       io_fflags;
  logic             io_fflagsClear = 1'b0;
  logic [1:0]       io_count;

  int checks = 0;
  int failures = 0;

  fn_from_rec_fn_wb #(.TAG_W(TAG_W), .DEPTH(2)) dut (
    .clock(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_rec(io_in_bits_rec), .io_in_bits_flags(io_in_bits_flags),
    .io_in_bits_tag(io_in_bits_tag),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_data(io_out_bits_data), .io_out_bits_tag(io_out_bits_tag),
    .io_fflags(io_fflags), .io_fflagsClear(io_fflagsClear), .io_count(io_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference conversion from the numeric meaning of recFN (true exponent = exp - 2048).
  function automatic logic [63:0] model_conv(input logic [64:0] rec);
    int          e;
    int          sh;
    logic [52:0] m;
    logic [52:0] frac;
    logic [10:0] eo;
    e = int'(rec[63:52]);
    m = {1'b1, rec[51:0]};
    if (e < 512) return {rec[64], 63'd0};
    if (e >= 3584) return {rec[64], 11'h7FF, rec[51:0]};
    if (e >= 3072) return {rec[64], 11'h7FF, 52'd0};
    if (e < 1026) begin
      sh = ((1 - e) % 64 + 64) % 64 + 1;
      frac = m >> sh;
      return {rec[64], 11'd0, frac[51:0]};
    end
    eo = 11'((e - 1025) % 2048);
    return {rec[64], eo, rec[51:0]};
  endfunction

  logic [63+TAG_W:0] mq[$];
  logic [4:0]        mflags = 5'd0;

  // Model update on each rising edge, then compare shortly after.
  always @(posedge clk) begin
    bit in_f, out_f;
    if (reset) begin
      mq.delete();
      mflags = 5'd0;
    end else begin
      in_f  = io_in_valid && (mq.size() < 2);
      out_f = io_out_ready && (mq.size() > 0);
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back({model_conv(io_in_bits_rec), io_in_bits_tag});
      if (in_f) mflags = (io_fflagsClear ? 5'd0 : mflags) | io_in_bits_flags;
      else if (io_fflagsClear) mflags = 5'd0;
    end
    #1;
    if (!reset) begin
      check("m_out_valid", 64'(io_out_valid), 64'(mq.size() != 0));
      check("m_count", 64'(io_count), 64'(mq.size()));
      check("m_in_ready", 64'(io_in_ready), 64'(mq.size() < 2));
      check("m_fflags", 64'(io_fflags), 64'(mflags));
      if (mq.size() != 0) begin
        check("m_data", io_out_bits_data, mq[0][63+TAG_W:TAG_W]);
        check("m_tag", 64'(io_out_bits_tag), 64'(mq[0][TAG_W-1:0]));
      end else begin
        check("m_data_empty", io_out_bits_data, 64'd0);
        check("m_tag_empty", 64'(io_out_bits_tag), 64'd0);
      end
    end
  end

  task automatic send_lit(input string name, input logic [64:0] rec, input logic [4:0] tag,
                          input logic [63:0] exp_data);
    io_out_ready = 1'b1;
    @(negedge clk);
    io_in_valid = 1'b1; io_in_bits_rec = rec; io_in_bits_tag = tag; io_in_bits_flags = 5'd0;
    @(negedge clk);
    io_in_valid = 1'b0;
    check({name, "_valid"}, 64'(io_out_valid), 64'd1);
    check({name, "_data"}, io_out_bits_data, exp_data);
    check({name, "_tag"}, 64'(io_out_bits_tag), 64'(tag));
    check({name, "_model"}, model_conv(rec), exp_data);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(io_out_valid), 64'd0);
    check("rst_count", 64'(io_count), 64'd0);
    check("rst_fflags", 64'(io_fflags), 64'd0);
    check("rst_data", io_out_bits_data, 64'd0);
    check("rst_tag", 64'(io_out_bits_tag), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(io_out_valid), 64'd0);
    check("post_rst_ready", 64'(io_in_ready), 64'd1);

    send_lit("one",     65'h08000000000000000, 5'd3, 64'h3FF0000000000000);
    send_lit("negzero", 65'h10000000000000000, 5'd4, 64'h8000000000000000);
    send_lit("inf",     65'h0C000000000000000, 5'd5, 64'h7FF0000000000000);
    send_lit("nan",     65'h0E008000000000000, 5'd6, 64'h7FF8000000000000);
    send_lit("minsub",  65'h03CE0000000000000, 5'd7, 64'h0000000000000001);
    send_lit("exp1025", 65'h04010000000000000, 5'd8, 64'h0008000000000000);
    send_lit("two",     65'h08010000000000000, 5'd9, 64'h4000000000000000);
    @(negedge clk);

    // Back-pressure: three back-to-back enqueues with writeback stalled.
    io_out_ready = 1'b0;
    io_in_valid = 1'b1; io_in_bits_rec = 65'h08000000000000000; io_in_bits_tag = 5'd1;
    @(negedge clk); io_in_bits_tag = 5'd2;
    @(negedge clk); io_in_bits_tag = 5'd3;
    check("bp_in_ready", 64'(io_in_ready), 64'd0);
    check("bp_count", 64'(io_count), 64'd2);
    @(negedge clk);
    check("bp_hold_count", 64'(io_count), 64'd2);
    check("bp_head1", 64'(io_out_bits_tag), 64'd1);
    io_out_ready = 1'b1;
    @(negedge clk);
    check("bp_head2", 64'(io_out_bits_tag), 64'd2);
    @(negedge clk);
    check("bp_head3", 64'(io_out_bits_tag), 64'd3);
    check("bp_count1", 64'(io_count), 64'd1);
    io_in_valid = 1'b0;
    @(negedge clk);
    check("bp_empty", 64'(io_out_valid), 64'd0);

    // Sticky flags accumulate at enqueue; clear merges with a simultaneous enqueue.
    io_fflagsClear = 1'b1;
    @(negedge clk);
    io_fflagsClear = 1'b0; io_in_valid = 1'b1; io_in_bits_flags = 5'b00001;
    @(negedge clk);
    io_in_bits_flags = 5'b10000;
    @(negedge clk);
    io_in_valid = 1'b0;
    check("flags_acc", 64'(io_fflags), 64'h11);
    io_fflagsClear = 1'b1; io_in_valid = 1'b1; io_in_bits_flags = 5'b00100;
    @(negedge clk);
    io_fflagsClear = 1'b0; io_in_valid = 1'b0;
    check("flags_clr_enq", 64'(io_fflags), 64'h04);
    @(negedge clk);

    // Asynchronous reset while full with flags set.
    io_out_ready = 1'b0; io_in_valid = 1'b1; io_in_bits_flags = 5'b00010;
    repeat (2) @(negedge clk);
    io_in_valid = 1'b0; io_in_bits_flags = 5'd0;
    check("full_count", 64'(io_count), 64'd2);
    check("full_fflags", 64'(io_fflags), 64'h06);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(io_out_valid), 64'd0);
    check("arst_count", 64'(io_count), 64'd0);
    check("arst_fflags", 64'(io_fflags), 64'd0);
    check("arst_data", io_out_bits_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_valid", 64'(io_out_valid), 64'd0);
    send_lit("after_rst", 65'h08000000000000000, 5'd11, 64'h3FF0000000000000);

    // Mixed traffic checked against the model every cycle.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      io_in_valid      = 1'($urandom_range(0, 1));
      io_out_ready     = ($urandom_range(0, 3) != 0);
      io_in_bits_rec   = {1'($urandom), 32'($urandom), 32'($urandom)};
      io_in_bits_tag   = TAG_W'($urandom);
      io_in_bits_flags = 5'($urandom);
      io_fflagsClear   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    io_in_valid = 1'b0; io_out_ready = 1'b1; io_fflagsClear = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_empty", 64'(io_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
